alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 16-bit ALU.
- Accepts decoded operations from decode/register-read and forms the ALU operands: the immediate is selected and sign- or zero-extended here.
- A 2-entry skid buffer presents registered A, B and AluOp to the ALU with a valid/ready handshake.
- Downstream stalls never create a combinational ready path back to decode, and full throughput is kept.

Parameters:
WIDTH, 16, operand width (ALU data width)
IMM_WIDTH, 8, raw immediate width from decode (1 <= IMM_WIDTH <= WIDTH)

Ports:
CLK  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous discard of all buffered entries
InValid  input  1  decode presents an operation
InReady  output  1  stage can accept (registered)
InRsVal  input  WIDTH  first source register value
InRtVal  input  WIDTH  second source register value
InImm  input  IMM_WIDTH  raw immediate
InUseImm  input  1  1: B comes from the extended immediate; 0: B = InRtVal
InSignExt  input  1  1: sign-extend the immediate; 0: zero-extend it
InAluOp  input  3  ALU operation code
OutValid  output  1  A/B/AluOp hold a valid operation
OutReady  input  1  ALU/execute consumes this cycle
A  output  WIDTH  operand A to the ALU
B  output  WIDTH  operand B to the ALU
AluOp  output  3  opcode to the ALU
IllegalOp  output  1  one-cycle pulse: a reserved opcode was accepted
Occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (Reset_n low, asynchronous): both entries invalid. A=0, B=0, AluOp=0, OutValid=0, IllegalOp=0, Occupancy=0, InReady=1. All outputs hold these values while Reset_n is low.
- Operand formation (combinational, on the input side before storage):
  - opA = InRsVal.
  - ext = InSignExt ? sign-extension of InImm to WIDTH : zero-extension of InImm to WIDTH.
  - opB = InUseImm ? ext : InRtVal.
- Opcode check: the valid codes are 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 sgt, 110 seq. Code 111 is reserved: it is stored as 000 and IllegalOp=1 in the cycle after acceptance, 0 otherwise.
- Handshake:
  - Accept = InValid & InReady.
  - Issue = OutValid & OutReady.
  - Input fields are don't-care when InValid=0.
- Storage: main entry (drives A/B/AluOp/OutValid) and skid entry. InReady = ~skid_valid, taken from a flop only.
- Next-state table, evaluated per edge:
  - Main empty, accept: load main. OutValid=1 next cycle (1-cycle latency).
  - Main full, issue, no accept: main <= skid if skid valid, otherwise main empties.
  - Main full, issue, accept: if skid empty, main <= new; if skid valid, main <= skid and skid <= new.
  - Main full, no issue, accept: skid <= new. InReady=0 next cycle.
  - Skid full, no issue: hold. InReady=0 and no accept is possible.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Stability: while OutValid=1 and OutReady=0, A/B/AluOp hold constant.
- Throughput: with OutReady held 1, one operation per cycle sustained and Occupancy stays at 1 or less.
- Flush:
  - Highest priority. At the next edge both entries are invalid, Occupancy=0, OutValid=0, InReady=1 and IllegalOp=0.
  - Any beat accepted in the Flush cycle is discarded.
  - An issue in the Flush cycle is still counted as consumed by downstream.
- Occupancy = main_valid + skid_valid, registered.
- Reset asserted mid-operation: immediate return to the reset state and buffered entries are lost. On release, the first accept is possible at the first rising edge.

Test Plan:
1. Reset, then InValid=1, InRsVal=0x1234, InRtVal=0x0F0F, InUseImm=0, InAluOp=010, OutReady=1. Required: next cycle OutValid=1, A=0x1234, B=0x0F0F, AluOp=010.
2. InImm=0x80, InUseImm=1: with InSignExt=1 -> B=0xFF80; with InSignExt=0 -> B=0x0080. With InImm=0x7F and InSignExt=1 -> B=0x007F.
3. OutReady=0, three back-to-back beats X, Y, Z offered. Required: X in main and Y in skid, InReady=0 from cycle 2, Occupancy=2, Z held by upstream. Then OutReady=1 -> issue order X, Y, Z with no loss or duplication; A stays at X while stalled.
4. Continuous InValid=1 and OutReady=1 for 20 beats with incrementing InRsVal 0..19. Required: A=0..19 in consecutive cycles, InReady constantly 1.
5. InAluOp=111 accepted. Required: AluOp=000 on output and IllegalOp=1 for exactly one cycle. A following 110 -> AluOp=110, IllegalOp=0.
6. Occupancy=2 with Flush=1 and InValid=1 in the same cycle. Required next cycle: Occupancy=0, OutValid=0, InReady=1, no beat from before or during the flush ever issued. Separately, Reset_n pulsed low mid-stream -> all outputs 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : ALU issue stage. Forms operands (immediate extension, opcode
//             screening) and presents them through a 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     InRsVal,
    input  logic [WIDTH-1:0]     InRtVal,
    input  logic [IMM_WIDTH-1:0] InImm,
    input  logic                 InUseImm,
    input  logic                 InSignExt,
    input  logic [2:0]           InAluOp,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [2:0]           AluOp,
    output logic                 IllegalOp,
    output logic [1:0]           Occupancy
);

    localparam logic [2:0] C_OP_RESERVED = 3'b111;
    localparam logic [2:0] C_OP_AND      = 3'b000;

    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_opb;
    logic [2:0]       w_op;
    logic             w_illegal;
    logic             w_accept;
    logic             w_issue;

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_a;
    logic [WIDTH-1:0] r_main_b;
    logic [2:0]       r_main_op;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic [2:0]       r_skid_op;
    logic             r_illegal;
    logic [1:0]       r_occ;

    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_load_main_new;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // A zero-width replication is illegal, so the full-width case is split out
    generate
        if (IMM_WIDTH >= WIDTH) begin : g_ext_full
            assign w_ext = InImm[WIDTH-1:0];
        end else begin : g_ext_pad
            assign w_ext = {{(WIDTH-IMM_WIDTH){InSignExt & InImm[IMM_WIDTH-1]}}, InImm};
        end
    endgenerate

    assign w_opb     = InUseImm ? w_ext : InRtVal;
    assign w_illegal = (InAluOp == C_OP_RESERVED);
    assign w_op      = w_illegal ? C_OP_AND : InAluOp;

    // Ready comes straight from the skid flop: no combinational path from OutReady
    assign InReady  = ~r_skid_valid;
    assign w_accept = InValid & ~r_skid_valid;
    assign w_issue  = r_main_valid & OutReady;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (Flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_load_main_new  = 1'b1;
            end
        end else if (w_issue) begin
            if (r_skid_valid) begin
                w_load_main_skid = 1'b1;
                w_load_skid      = w_accept;
                w_skid_valid_nxt = w_accept;
            end else if (w_accept) begin
                w_load_main_new  = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_load_skid      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_op    <= '0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_op    <= '0;
            r_illegal    <= 1'b0;
            r_occ        <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_occ        <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
            r_illegal    <= w_accept & w_illegal & ~Flush;
            if (w_load_main_new) begin
                r_main_a  <= InRsVal;
                r_main_b  <= w_opb;
                r_main_op <= w_op;
            end else if (w_load_main_skid) begin
                r_main_a  <= r_skid_a;
                r_main_b  <= r_skid_b;
                r_main_op <= r_skid_op;
            end
            if (w_load_skid) begin
                r_skid_a  <= InRsVal;
                r_skid_b  <= w_opb;
                r_skid_op <= w_op;
            end
        end
    end

    assign OutValid  = r_main_valid;
    assign A         = r_main_a;
    assign B         = r_main_b;
    assign AluOp     = r_main_op;
    assign IllegalOp = r_illegal;
    assign Occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Self-checking bench for alu_operand_stage against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_operand_stage;

    localparam int WIDTH     = 16;
    localparam int IMM_WIDTH = 8;

    logic                 CLK = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 Flush = 1'b0;
    logic                 InValid = 1'b0;
    logic                 InReady;
    logic [WIDTH-1:0]     InRsVal = '0;
    logic [WIDTH-1:0]     InRtVal = '0;
    logic [IMM_WIDTH-1:0] InImm = '0;
    logic                 InUseImm = 1'b0;
    logic                 InSignExt = 1'b0;
    logic [2:0]           InAluOp = '0;
    logic                 OutValid;
    logic                 OutReady = 1'b0;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           AluOp;
    logic                 IllegalOp;
    logic [1:0]           Occupancy;

    alu_operand_stage #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .InRsVal(InRsVal), .InRtVal(InRtVal), .InImm(InImm),
        .InUseImm(InUseImm), .InSignExt(InSignExt), .InAluOp(InAluOp),
        .OutValid(OutValid), .OutReady(OutReady),
        .A(A), .B(B), .AluOp(AluOp),
        .IllegalOp(IllegalOp), .Occupancy(Occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } beat_t;

    beat_t q[$];
    logic  exp_ill = 1'b0;
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand formation from first principles: the immediate is a number,
    // negative when sign extension is asked for and its top bit is set.
    function automatic beat_t form_beat();
        beat_t b;
        int    v;
        logic [WIDTH-1:0] e;
        v = int'(InImm);
        if (InSignExt && v >= (1 << (IMM_WIDTH-1)))
            v = v - (1 << IMM_WIDTH);
        e    = WIDTH'(v);
        b.a  = InRsVal;
        b.b  = InUseImm ? e : InRtVal;
        b.op = (InAluOp == 3'd7) ? 3'd0 : InAluOp;
        return b;
    endfunction

    // A 2-deep FIFO: accept when not full, issue when not empty
    task automatic model_step();
        bit    acc;
        bit    iss;
        beat_t nb;
        if (!Reset_n) begin
            q.delete();
            exp_ill = 1'b0;
            return;
        end
        acc = InValid && (q.size() < 2);
        iss = (q.size() > 0) && OutReady;
        nb  = form_beat();
        if (Flush) begin
            q.delete();
            exp_ill = 1'b0;
        end else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(nb);
            exp_ill = acc && (InAluOp == 3'd7);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("outvalid", 32'(OutValid), 32'(q.size() > 0));
            chk("inready", 32'(InReady), 32'(q.size() < 2));
            chk("occupancy", 32'(Occupancy), 32'(q.size()));
            chk("illegalop", 32'(IllegalOp), 32'(exp_ill));
            if (q.size() > 0) begin
                chk("a", 32'(A), 32'(q[0].a));
                chk("b", 32'(B), 32'(q[0].b));
                chk("aluop", 32'(AluOp), 32'(q[0].op));
            end
            if (!Reset_n) begin
                chk("reset_a", 32'(A), 32'd0);
                chk("reset_b", 32'(B), 32'd0);
                chk("reset_aluop", 32'(AluOp), 32'd0);
            end
        end
    end

    task automatic cycle(input bit v, input logic [15:0] rs, input logic [15:0] rt,
                         input logic [7:0] imm, input bit ui, input bit se,
                         input logic [2:0] op, input bit ordy, input bit fl);
        InValid   = v;
        InRsVal   = rs;
        InRtVal   = rt;
        InImm     = imm;
        InUseImm  = ui;
        InSignExt = se;
        InAluOp   = op;
        OutReady  = ordy;
        Flush     = fl;
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 3'd0, ordy, 1'b0);
    endtask

    initial begin
        chk_en = 1'b1;
        idle(1'b0);
        idle(1'b0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_occ", 32'(Occupancy), 32'd0);
        Reset_n = 1'b1;

        // Register operands, 1-cycle latency
        cycle(1'b1, 16'h1234, 16'h0F0F, 8'h00, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0);
        chk("t1_outvalid", 32'(OutValid), 32'd1);
        chk("t1_a", 32'(A), 32'h1234);
        chk("t1_b", 32'(B), 32'h0F0F);
        chk("t1_aluop", 32'(AluOp), 32'd2);

        // Immediate extension
        cycle(1'b1, 16'h0001, 16'h5555, 8'h80, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
        chk("t2_sext80", 32'(B), 32'hFF80);
        cycle(1'b1, 16'h0002, 16'h5555, 8'h80, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
        chk("t2_zext80", 32'(B), 32'h0080);
        cycle(1'b1, 16'h0003, 16'h5555, 8'h7F, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
        chk("t2_sext7f", 32'(B), 32'h007F);
        idle(1'b1);

        // Stall with X, Y, Z offered back to back
        cycle(1'b1, 16'hAAA1, 16'h0, 8'h0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        chk("t3_x_main", 32'(A), 32'hAAA1);
        cycle(1'b1, 16'hAAA2, 16'h0, 8'h0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        chk("t3_inready0", 32'(InReady), 32'd0);
        chk("t3_occ2", 32'(Occupancy), 32'd2);
        chk("t3_a_stall", 32'(A), 32'hAAA1);
        cycle(1'b1, 16'hAAA3, 16'h0, 8'h0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        chk("t3_a_hold", 32'(A), 32'hAAA1);
        cycle(1'b1, 16'hAAA3, 16'h0, 8'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        chk("t3_y", 32'(A), 32'hAAA2);
        cycle(1'b1, 16'hAAA3, 16'h0, 8'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        chk("t3_z", 32'(A), 32'hAAA3);
        idle(1'b1);

        // Full-throughput streaming
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'(i), 16'h0, 8'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
            chk("t4_a", 32'(A), 32'(i));
            chk("t4_inready", 32'(InReady), 32'd1);
        end
        idle(1'b1);

        // Reserved opcode
        cycle(1'b1, 16'h0077, 16'h0, 8'h0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);
        chk("t5_aluop0", 32'(AluOp), 32'd0);
        chk("t5_illegal1", 32'(IllegalOp), 32'd1);
        cycle(1'b1, 16'h0078, 16'h0, 8'h0, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0);
        chk("t5_aluop6", 32'(AluOp), 32'd6);
        chk("t5_illegal0", 32'(IllegalOp), 32'd0);
        idle(1'b1);

        // Flush with both entries full and a beat offered
        cycle(1'b1, 16'hBBB1, 16'h0, 8'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBB2, 16'h0, 8'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBB3, 16'h0, 8'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1);
        chk("t6_occ0", 32'(Occupancy), 32'd0);
        chk("t6_outvalid0", 32'(OutValid), 32'd0);
        chk("t6_inready1", 32'(InReady), 32'd1);
        cycle(1'b1, 16'hBBB4, 16'h0, 8'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        chk("t6_after_flush", 32'(A), 32'hBBB4);
        idle(1'b1);

        // Asynchronous reset mid-stream
        cycle(1'b1, 16'hCCC1, 16'h1111, 8'h0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCC2, 16'h2222, 8'h0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        #1;
        Reset_n = 1'b0;
        q.delete();
        exp_ill = 1'b0;
        #1;
        chk("ar_a", 32'(A), 32'd0);
        chk("ar_b", 32'(B), 32'd0);
        chk("ar_aluop", 32'(AluOp), 32'd0);
        chk("ar_outvalid", 32'(OutValid), 32'd0);
        chk("ar_illegal", 32'(IllegalOp), 32'd0);
        chk("ar_occ", 32'(Occupancy), 32'd0);
        chk("ar_inready", 32'(InReady), 32'd1);
        idle(1'b0);
        Reset_n = 1'b1;
        cycle(1'b1, 16'hDDD1, 16'h0, 8'h0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);
        chk("ar_first_accept", 32'(A), 32'hDDD1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        @(negedge CLK);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
